sprite_scanline_scheduler: RTL and testbench
============================================

# sprite_scanline_scheduler

Per-scanline controller that sequences the shared `sprite_line_counter` across a table of sprites. On each `line_start` it scans the sprite attribute table in index order. Every active sprite whose vertical span covers the requested line is handed to the line counter, one at a time, and the scheduler waits for `count_finished` before moving on. It sits between the sprite register bank and `sprite_line_counter` in the pixel-clock domain.

## Interface
Parameters:
- `N_SPRITES`, default 32: table entries; index width `IDX_W = clog2(N_SPRITES)`.
- `MAX_PER_LINE`, default 8: maximum sprites launched per line.
- `SPRITE_H`, default 20: sprite height in lines; matches `size_line`.
- `size_y`, default 9: line coordinate width.

Ports (clock and reset first):
- `clk_pixel` in 1: pixel clock; one clock domain; all logic rising-edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `line_start` in 1: one-cycle pulse requesting a scan for `line_y`.
- `line_y` in `size_y`: line to prepare; sampled on `line_start`.
- `tbl_addr` out `IDX_W`: sprite table read address.
- `tbl_rd_data` in 32: table word; valid one cycle after `tbl_addr`.
  - Format: [31:22] x, [21:13] y, [12:5] offset, [4:1] reserved, [0] active.
- `count_finished` in 1: from the line counter; current sprite done.
- `sprite_on` out 1: enable to the line counter.
- `sprite_datas` out 32: table word forwarded to the line counter.
- `sprite_index` out `IDX_W`: index of the launched sprite.
- `busy` out 1: high in any state other than IDLE.
- `line_done` out 1: one-cycle pulse when the scan completes.
- `overflow` out 1: more than `MAX_PER_LINE` hits on this line.
- `line_late` out 1: one-cycle pulse when `line_start` aborts a scan in progress.
- `hit_count` out `clog2(MAX_PER_LINE+1)`: sprites launched this line.

## Operation
- **State machine**: IDLE, FETCH, CHECK, LAUNCH, DONE.
- **IDLE**: on `line_start`, latch `line_y` → `cur_y`, clear `i`, `hit_count` and `overflow`, go to FETCH.
- **FETCH**: drive `tbl_addr = i`, go to CHECK.
- **CHECK**: register `tbl_rd_data`, then evaluate the hit condition.
  - Hit = `active` && `y <= cur_y` && `(cur_y - y) < SPRITE_H`.
  - Compute the subtraction in `size_y+1` bits; there is no vertical wrap.
  - A sprite at y=500 never covers line 3.
  - Hit with `hit_count < MAX_PER_LINE`: load `sprite_datas`, set `sprite_index = i`, go to LAUNCH.
  - Hit with `hit_count == MAX_PER_LINE`: set `overflow`, go to DONE (scan ends).
  - Miss: if `i == N_SPRITES-1` go to DONE, otherwise `i+1`, go to FETCH.
- **LAUNCH**: `sprite_on = 1`; hold `sprite_datas` stable.
  - On `count_finished` sampled high: deassert `sprite_on` and increment `hit_count`.
  - Then go to DONE if `i == N_SPRITES-1`, otherwise `i+1` and go to FETCH.
- **DONE**: pulse `line_done`, go to IDLE.
- `overflow` and `hit_count` hold until the next accepted `line_start`.
- **`line_start` outside IDLE**: abort immediately.
  - Drop `sprite_on` and pulse `line_late`.
  - Re-latch `line_y` and restart at FETCH with `i = 0` (same clears as IDLE).
  - No `line_done` is issued for the aborted line.
- **`line_start` coincident with `count_finished`**: the abort wins; `hit_count` is cleared.
- **Reset** (any time, asynchronous): state IDLE; all outputs 0; `sprite_datas = 0`.

## Timing
- `line_start` at edge k: FETCH at k+1 with `tbl_addr = 0`, CHECK at k+2.
- Miss cost: 2 cycles per entry.
- Hit: `sprite_on` is high from the cycle after CHECK.
- After `count_finished` is sampled at edge m: `sprite_on` is low at m+1 and the next FETCH is at m+1.
- Empty table (no hits): `line_done` is high exactly `2*N_SPRITES + 1` cycles after `line_start` (65 for defaults).
- `count_finished` is ignored outside LAUNCH.
- `sprite_on` never spans two sprites; there is at least 1 low cycle between launches.

## Test plan
- **Reset**: assert `reset = 0` mid-LAUNCH → all outputs 0 asynchronously; state IDLE after release.
- **Empty table** (all `active = 0`), `line_start` with `line_y = 32` → `line_done` at cycle 65, `hit_count = 0`, `sprite_on` never high.
- **Single sprite**: entry 5 = {x 32, y 32, offset 8, active 1}, `line_y = 51` → hit; `sprite_index = 5`; `sprite_datas` equal to the entry; `sprite_on` held until the modelled `count_finished` (10 cycles later); `hit_count = 1`.
- **Span boundaries**: same sprite with `line_y = 52` → miss; `line_y = 31` → miss; `line_y = 32` → hit.
- **Overflow**: 10 active sprites all at y = 0, `line_y = 0` → 8 launches in index order; `overflow = 1`; `hit_count = 8`; `line_done` pulses.
- **Late line**: `line_start` during the third launch → `line_late` pulse, `sprite_on` low the next cycle, `hit_count = 0`, scan restarts at `tbl_addr = 0` with the new `line_y`.

Source files
------------

// File: rtl/sprite_scanline_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table on line_start and hands
// each active sprite covering the line to the shared line counter in index order.
module sprite_scanline_scheduler #(
    parameter int N_SPRITES    = 32,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_H     = 20,
    parameter int size_y       = 9,
    localparam int IDX_W       = $clog2(N_SPRITES),
    localparam int HC_W        = $clog2(MAX_PER_LINE + 1)
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              line_start,
    input  logic [size_y-1:0] line_y,
    output logic [IDX_W-1:0]  tbl_addr,
    input  logic [31:0]       tbl_rd_data,
    input  logic              count_finished,
    output logic              sprite_on,
    output logic [31:0]       sprite_datas,
    output logic [IDX_W-1:0]  sprite_index,
    output logic              busy,
    output logic              line_done,
    output logic              overflow,
    output logic              line_late,
    output logic [HC_W-1:0]   hit_count
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_SPRITES - 1);
    localparam logic [HC_W-1:0]  MAX_HC     = HC_W'(MAX_PER_LINE);
    localparam logic [size_y:0]  SPRITE_H_W = (size_y + 1)'(SPRITE_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_LAUNCH,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [size_y-1:0]   r_cur_y;
    logic [IDX_W-1:0]    r_i;
    logic [HC_W-1:0]     r_hit_count;
    logic                r_overflow;
    logic                r_line_late;
    logic [31:0]         r_sprite_datas;
    logic [IDX_W-1:0]    r_sprite_index;

    logic                w_start;
    logic                w_abort;
    logic                w_load;
    logic                w_i_inc;
    logic                w_hc_inc;
    logic                w_set_ovf;
    logic                w_last;
    logic                w_hit;
    logic [size_y:0]     w_y_ext;
    logic [size_y:0]     w_cur_ext;
    logic [size_y:0]     w_diff;

    // One extra bit keeps the span test free of vertical wrap-around.
    assign w_y_ext   = (size_y + 1)'(tbl_rd_data[21:13]);
    assign w_cur_ext = {1'b0, r_cur_y};
    assign w_diff    = w_cur_ext - w_y_ext;
    assign w_hit     = tbl_rd_data[0] && (w_y_ext <= w_cur_ext) && (w_diff < SPRITE_H_W);
    assign w_last    = (r_i == LAST_IDX);

    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_load      = 1'b0;
        w_i_inc     = 1'b0;
        w_hc_inc    = 1'b0;
        w_set_ovf   = 1'b0;
        if (line_start) begin
            // A new line always wins; it only counts as late if a scan was still running.
            w_start     = 1'b1;
            w_abort     = (r_state != S_IDLE) && (r_state != S_DONE);
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_FETCH: w_state_nxt = S_CHECK;
                S_CHECK: begin
                    if (w_hit && (r_hit_count < MAX_HC)) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_LAUNCH;
                    end else if (w_hit) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_inc     = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_LAUNCH: begin
                    if (count_finished) begin
                        w_hc_inc    = 1'b1;
                        w_i_inc     = !w_last;
                        w_state_nxt = w_last ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            r_cur_y        <= '0;
            r_i            <= '0;
            r_hit_count    <= '0;
            r_overflow     <= 1'b0;
            r_line_late    <= 1'b0;
            r_sprite_datas <= '0;
            r_sprite_index <= '0;
        end else begin
            r_line_late <= w_abort;
            if (w_start) begin
                r_cur_y     <= line_y;
                r_i         <= '0;
                r_hit_count <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_i_inc)   r_i         <= r_i + IDX_W'(1);
                if (w_hc_inc)  r_hit_count <= r_hit_count + HC_W'(1);
                if (w_set_ovf) r_overflow  <= 1'b1;
                if (w_load) begin
                    r_sprite_datas <= tbl_rd_data;
                    r_sprite_index <= r_i;
                end
            end
        end
    end

    assign tbl_addr     = r_i;
    assign sprite_on    = (r_state == S_LAUNCH);
    assign sprite_datas = r_sprite_datas;
    assign sprite_index = r_sprite_index;
    assign busy         = (r_state != S_IDLE);
    assign line_done    = (r_state == S_DONE);
    assign overflow     = r_overflow;
    assign line_late    = r_line_late;
    assign hit_count    = r_hit_count;

endmodule

// File: tb/tb_sprite_scanline_scheduler.sv
// Directed bench for sprite_scanline_scheduler: synchronous table model plus a
// line-counter responder that finishes each launched sprite after a fixed delay.
module tb_sprite_scanline_scheduler;

    localparam int N        = 32;
    localparam int CF_DELAY = 10;
    localparam logic [31:0] W5 = 32'h0804_0101;  // x 32, y 32, offset 8, active
    localparam logic [31:0] W7 = 32'h003E_8001;  // y 500, active

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        line_start;
    logic [8:0]  line_y;
    logic [4:0]  tbl_addr;
    logic [31:0] tbl_rd_data;
    logic        count_finished;
    logic        cf_auto = 1'b0;
    logic        cf_manual;
    logic        auto_cf;
    logic        sprite_on;
    logic [31:0] sprite_datas;
    logic [4:0]  sprite_index;
    logic        busy;
    logic        line_done;
    logic        overflow;
    logic        line_late;
    logic [3:0]  hit_count;

    logic [31:0] mem [0:N-1];
    int          vectors = 0;
    int          errors  = 0;
    int          on_cnt  = 0;
    int          n_fin   = 0;
    logic [4:0]  fin_idx [0:255];
    logic [31:0] fin_dat [0:255];

    sprite_scanline_scheduler dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .line_start     (line_start),
        .line_y         (line_y),
        .tbl_addr       (tbl_addr),
        .tbl_rd_data    (tbl_rd_data),
        .count_finished (count_finished),
        .sprite_on      (sprite_on),
        .sprite_datas   (sprite_datas),
        .sprite_index   (sprite_index),
        .busy           (busy),
        .line_done      (line_done),
        .overflow       (overflow),
        .line_late      (line_late),
        .hit_count      (hit_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) tbl_rd_data <= mem[tbl_addr];

    assign count_finished = cf_auto | cf_manual;

    // Line-counter model: finishes a sprite CF_DELAY cycles after sprite_on rises.
    always begin
        @(posedge clk_pixel);
        #2;
        if (auto_cf && sprite_on) begin
            on_cnt = on_cnt + 1;
            if (on_cnt == CF_DELAY) begin
                cf_auto        = 1'b1;
                fin_idx[n_fin] = sprite_index;
                fin_dat[n_fin] = sprite_datas;
                n_fin          = n_fin + 1;
            end else begin
                cf_auto = 1'b0;
            end
        end else begin
            on_cnt  = 0;
            cf_auto = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic clear_mem();
        for (int j = 0; j < N; j++) mem[j] = 32'h0;
    endtask

    task automatic run_line(input logic [8:0] y, output int done_tick, output int on_ticks,
                            output int rises, output int first_on);
        logic prev_on;
        tick();
        line_y     = y;
        line_start = 1'b1;
        done_tick  = -1;
        on_ticks   = 0;
        rises      = 0;
        first_on   = -1;
        prev_on    = 1'b0;
        for (int t = 1; t <= 2000; t++) begin
            tick();
            line_start = 1'b0;
            if (sprite_on) begin
                on_ticks++;
                if (!prev_on) rises++;
                if (first_on < 0) first_on = t;
            end
            prev_on = sprite_on;
            if (line_done) begin
                done_tick = t;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; line_start = 1'b0; line_y = '0; cf_manual = 1'b0; auto_cf = 1'b0;
        clear_mem();
        #2 reset = 1'b0;
        #2;
        vectors++;
        if ({sprite_on, busy, line_done, overflow, line_late, hit_count, tbl_addr, sprite_index} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {sprite_on, busy, line_done, overflow, line_late, hit_count, tbl_addr, sprite_index});
        end
        vectors++;
        if (sprite_datas !== 32'h0) begin
            errors++; $display("FAIL reset_datas: got %h required 0", sprite_datas);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b required 0", busy); end
    endtask

    task automatic test_empty_table();
        int done_t = -1;
        logic seen_on = 1'b0;
        auto_cf = 1'b1;
        clear_mem();
        tick();
        line_y = 9'd32; line_start = 1'b1;
        for (int t = 1; t <= 200; t++) begin
            tick();
            line_start = 1'b0;
            if (sprite_on) seen_on = 1'b1;
            if (t == 1) begin
                vectors++;
                if (busy !== 1'b1 || tbl_addr !== 5'd0) begin
                    errors++; $display("FAIL empty_fetch0: busy %b addr %0d required 1/0", busy, tbl_addr);
                end
            end
            if (t == 3) begin
                vectors++;
                if (tbl_addr !== 5'd1) begin
                    errors++; $display("FAIL empty_fetch1: addr %0d required 1", tbl_addr);
                end
            end
            if (line_done) begin done_t = t; break; end
        end
        vectors++;
        if (done_t !== 65) begin errors++; $display("FAIL empty_done_cycle: got %0d required 65", done_t); end
        vectors++;
        if (hit_count !== 4'd0 || seen_on !== 1'b0) begin
            errors++; $display("FAIL empty_hits: hit_count %0d sprite_on_seen %b required 0/0", hit_count, seen_on);
        end
    endtask

    task automatic test_single_sprite();
        int d, on, r, f, base;
        clear_mem();
        mem[5] = W5;
        mem[7] = W7;
        base = n_fin;
        run_line(9'd51, d, on, r, f);
        vectors++;
        if (d !== 75 || f !== 13 || on !== CF_DELAY) begin
            errors++; $display("FAIL single_timing: done %0d first_on %0d on %0d required 75/13/%0d", d, f, on, CF_DELAY);
        end
        vectors++;
        if (n_fin - base !== 1 || fin_idx[base] !== 5'd5 || fin_dat[base] !== W5) begin
            errors++; $display("FAIL single_launch: count %0d idx %0d data %h required 1/5/%h",
                               n_fin - base, fin_idx[base], fin_dat[base], W5);
        end
        vectors++;
        if (hit_count !== 4'd1 || overflow !== 1'b0 || sprite_index !== 5'd5) begin
            errors++; $display("FAIL single_status: hit_count %0d ovf %b index %0d required 1/0/5",
                               hit_count, overflow, sprite_index);
        end
    endtask

    task automatic test_span_boundaries();
        int d, on, r, f;
        logic [8:0] ys   [4] = '{9'd52, 9'd31, 9'd32, 9'd3};
        int         hits [4] = '{0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            run_line(ys[k], d, on, r, f);
            vectors++;
            if (hit_count !== 4'(hits[k]) || r !== hits[k] || d !== 65 + 10 * hits[k]) begin
                errors++; $display("FAIL span_y%0d: hit_count %0d launches %0d done %0d required %0d/%0d/%0d",
                                   ys[k], hit_count, r, d, hits[k], hits[k], 65 + 10 * hits[k]);
            end
        end
    endtask

    task automatic test_overflow();
        int d, on, r, f, base;
        logic ok;
        clear_mem();
        for (int j = 0; j < 10; j++) mem[j] = (32'(j) << 22) | 32'h1;
        base = n_fin;
        run_line(9'd0, d, on, r, f);
        vectors++;
        if (overflow !== 1'b1 || hit_count !== 4'd8 || d !== 99) begin
            errors++; $display("FAIL ovf_status: ovf %b hit_count %0d done %0d required 1/8/99", overflow, hit_count, d);
        end
        vectors++;
        if (r !== 8 || on !== 80 || n_fin - base !== 8) begin
            errors++; $display("FAIL ovf_launches: rises %0d on %0d fin %0d required 8/80/8", r, on, n_fin - base);
        end
        ok = 1'b1;
        for (int j = 0; j < 8; j++)
            if (fin_idx[base + j] !== 5'(j) || fin_dat[base + j] !== ((32'(j) << 22) | 32'h1)) ok = 1'b0;
        vectors++;
        if (ok !== 1'b1) begin errors++; $display("FAIL ovf_order: index order got wrong, required 0..7"); end
    endtask

    task automatic test_late_line();
        int base, done_t;
        logic extra = 1'b0;
        base = n_fin;
        done_t = -1;
        tick();
        line_y = 9'd0; line_start = 1'b1;
        for (int t = 1; t <= 29; t++) begin
            tick();
            line_start = 1'b0;
        end
        vectors++;
        if (sprite_on !== 1'b1 || sprite_index !== 5'd2) begin
            errors++; $display("FAIL late_third: sprite_on %b index %0d required 1/2", sprite_on, sprite_index);
        end
        line_y = 9'd100; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        vectors++;
        if (line_late !== 1'b1 || sprite_on !== 1'b0 || hit_count !== 4'd0 || tbl_addr !== 5'd0) begin
            errors++; $display("FAIL late_abort: late %b on %b hit_count %0d addr %0d required 1/0/0/0",
                               line_late, sprite_on, hit_count, tbl_addr);
        end
        tick();
        vectors++;
        if (line_late !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL late_pulse: late %b busy %b required 0/1", line_late, busy);
        end
        for (int t = 3; t <= 200; t++) begin
            tick();
            if (sprite_on || line_late) extra = 1'b1;
            if (line_done) begin done_t = t; break; end
        end
        vectors++;
        if (done_t !== 65 || extra !== 1'b0 || n_fin - base !== 2 || hit_count !== 4'd0) begin
            errors++; $display("FAIL late_rescan: done %0d extra %b fin %0d hit_count %0d required 65/0/2/0",
                               done_t, extra, n_fin - base, hit_count);
        end
    endtask

    task automatic test_coincident_abort();
        int done_t = -1;
        int wait_t = -1;
        clear_mem();
        mem[5] = W5;
        auto_cf = 1'b0;
        tick();
        line_y = 9'd51; line_start = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            line_start = 1'b0;
            if (sprite_on) begin wait_t = t; break; end
        end
        vectors++;
        if (wait_t !== 13) begin errors++; $display("FAIL coin_launch: sprite_on at %0d required 13", wait_t); end
        cf_manual = 1'b1; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        vectors++;
        if (line_late !== 1'b1 || hit_count !== 4'd0 || sprite_on !== 1'b0 || tbl_addr !== 5'd0) begin
            errors++; $display("FAIL coin_abort: late %b hit_count %0d on %b addr %0d required 1/0/0/0",
                               line_late, hit_count, sprite_on, tbl_addr);
        end
        tick();
        cf_manual = 1'b0;
        vectors++;
        if (hit_count !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL coin_cf_ignored: hit_count %0d busy %b required 0/1", hit_count, busy);
        end
        auto_cf = 1'b1;
        for (int t = 3; t <= 200; t++) begin
            tick();
            if (line_done) begin done_t = t; break; end
        end
        vectors++;
        if (done_t !== 75 || hit_count !== 4'd1) begin
            errors++; $display("FAIL coin_rescan: done %0d hit_count %0d required 75/1", done_t, hit_count);
        end
    endtask

    task automatic test_reset_mid_launch();
        int wait_t = -1;
        int d, on, r, f;
        auto_cf = 1'b0;
        tick();
        line_y = 9'd51; line_start = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            line_start = 1'b0;
            if (sprite_on) begin wait_t = t; break; end
        end
        vectors++;
        if (wait_t !== 13 || sprite_datas !== W5) begin
            errors++; $display("FAIL rst_setup: sprite_on at %0d datas %h required 13/%h", wait_t, sprite_datas, W5);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({sprite_on, busy, line_done, overflow, line_late, hit_count, tbl_addr, sprite_index} !== '0
            || sprite_datas !== 32'h0) begin
            errors++; $display("FAIL rst_async: outs %b datas %h required 0/0",
                               {sprite_on, busy, line_done, overflow, line_late, hit_count, tbl_addr, sprite_index},
                               sprite_datas);
        end
        tick();
        reset = 1'b1;
        tick(); tick();
        vectors++;
        if (busy !== 1'b0 || sprite_on !== 1'b0) begin
            errors++; $display("FAIL rst_release: busy %b on %b required 0/0", busy, sprite_on);
        end
        auto_cf = 1'b1;
        run_line(9'd51, d, on, r, f);
        vectors++;
        if (d !== 75 || hit_count !== 4'd1) begin
            errors++; $display("FAIL rst_recover: done %0d hit_count %0d required 75/1", d, hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_empty_table();
        test_single_sprite();
        test_span_boundaries();
        test_overflow();
        test_late_line();
        test_coincident_abort();
        test_reset_mid_launch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
